// File: rtl/boot_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM state encoding,
// response byte constants, default frame start marker and the running
// checksum helper.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  localparam logic [7:0] ACK_BYTE     = 8'h06;
  localparam logic [7:0] NAK_BYTE     = 8'h15;
  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

  // 8-bit wrap-around checksum step.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports: clk/rstb (async active-low reset), d_i async input, q_o synchronized output.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstb,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the async level through two flops.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_boot_loader.sv
// UART firmware boot loader. Parses SYNC, LEN_LO, LEN_HI, 4*N data bytes
// (little-endian words) and CSUM from the UART receiver, writes words to
// instruction RAM, and answers ACK/NAK through the UART transmitter.
// Ports: clk, rstb (async active-low), upgrade_en_b (async switch, active-low),
// rx_valid/rx_data (receiver), tx_busy/tx_valid/tx_data (transmitter),
// mem_wr_en/mem_addr/mem_wr_data (RAM write port), cpu_hold, done, error.
module uart_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         ADDR_W      = 12,
  parameter int         TIMEOUT_CYC = 500000,
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              upgrade_en_b,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int          GAP_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic              en_b_sync_s, en_s, in_frame_s, abort_s, timeout_s;
  logic [7:0]        len_lo_q, len_lo_d, acc_q, acc_d, resp_q, resp_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       word_q, word_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              full_q, full_d, len_ovf_q, len_ovf_d;
  logic              tx_valid_q, tx_valid_d, mem_wr_en_q, mem_wr_en_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic              done_q, done_d, error_q, error_d, cpu_hold_q, cpu_hold_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_en_sync (
    .clk  (clk),
    .rstb (rstb),
    .d_i  (upgrade_en_b),
    .q_o  (en_b_sync_s)
  );

  assign en_s       = ~en_b_sync_s;
  assign in_frame_s = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_CSUM);
  assign abort_s    = in_frame_s && !en_s;
  assign timeout_s  = in_frame_s && (gap_q >= GAP_W'(TIMEOUT_CYC));

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort and timeout override any received byte.
  always_comb begin
    state_d = state_q;
    if (abort_s || timeout_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = (en_s && rx_valid && rx_data == SYNC_BYTE) ? ST_LEN_LO : ST_IDLE;
        ST_LEN_LO: state_d = rx_valid ? ST_LEN_HI : ST_LEN_LO;
        ST_LEN_HI: begin
          if (rx_valid) begin
            state_d = ({rx_data, len_lo_q} != 16'd0) ? ST_DATA : ST_CSUM;
          end else begin
            state_d = ST_LEN_HI;
          end
        end
        ST_DATA:   state_d = (rx_valid && bidx_q == 2'd3 && cnt_q == 16'd1) ? ST_CSUM : ST_DATA;
        ST_CSUM:   state_d = rx_valid ? ST_RESP : ST_CSUM;
        ST_RESP:   state_d = tx_busy ? ST_RESP : ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values (all outputs are registered).
  always_comb begin
    len_lo_d      = len_lo_q;
    acc_d         = acc_q;
    resp_d        = resp_q;
    cnt_d         = cnt_q;
    bidx_d        = bidx_q;
    word_d        = word_q;
    full_d        = full_q;
    len_ovf_d     = len_ovf_q;
    tx_valid_d    = 1'b0;
    tx_data_d     = tx_data_q;
    mem_wr_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    done_d        = done_q;
    error_d       = error_q;
    gap_d         = (in_frame_s && !rx_valid) ? gap_q + GAP_W'(1) : '0;
    cpu_hold_d    = en_s || (state_d != ST_IDLE);

    // Advance after the write cycle so address is stable during the strobe;
    // the top address saturates and further writes are blocked.
    if (mem_wr_en_q) begin
      if (mem_addr_q == {ADDR_W{1'b1}}) begin
        full_d = 1'b1;
      end else begin
        mem_addr_d = mem_addr_q + ADDR_W'(1);
      end
    end else begin
      full_d = full_q;
    end

    if (abort_s || timeout_s) begin
      error_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_s && rx_valid && rx_data == SYNC_BYTE) begin
            done_d     = 1'b0;
            error_d    = 1'b0;
            acc_d      = 8'h00;
            bidx_d     = 2'd0;
            mem_addr_d = '0;
            full_d     = 1'b0;
            len_ovf_d  = 1'b0;
          end else begin
            acc_d = acc_q;
          end
        end
        ST_LEN_LO: begin
          if (rx_valid) begin
            len_lo_d = rx_data;
            acc_d    = csum_add(acc_q, rx_data);
          end else begin
            len_lo_d = len_lo_q;
          end
        end
        ST_LEN_HI: begin
          if (rx_valid) begin
            cnt_d     = {rx_data, len_lo_q};
            len_ovf_d = 32'({rx_data, len_lo_q}) > DEPTH;
            acc_d     = csum_add(acc_q, rx_data);
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            acc_d  = csum_add(acc_q, rx_data);
            bidx_d = bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              mem_wr_en_d   = !full_q;
              mem_wr_data_d = {rx_data, word_q};
              cnt_d         = cnt_q - 16'd1;
            end else begin
              word_d = {rx_data, word_q[23:8]};
            end
          end else begin
            bidx_d = bidx_q;
          end
        end
        ST_CSUM: begin
          if (rx_valid) begin
            resp_d = (rx_data == acc_q && !len_ovf_q) ? ACK_BYTE : NAK_BYTE;
          end else begin
            resp_d = resp_q;
          end
        end
        ST_RESP: begin
          if (!tx_busy) begin
            tx_valid_d = 1'b1;
            tx_data_d  = resp_q;
            if (resp_q == ACK_BYTE) begin
              done_d = 1'b1;
            end else begin
              error_d = 1'b1;
            end
          end else begin
            tx_valid_d = 1'b0;
          end
        end
        default: begin
          error_d = error_q;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      len_lo_q      <= 8'h00;
      acc_q         <= 8'h00;
      resp_q        <= 8'h00;
      cnt_q         <= 16'd0;
      bidx_q        <= 2'd0;
      word_q        <= 24'd0;
      gap_q         <= '0;
      full_q        <= 1'b0;
      len_ovf_q     <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      cpu_hold_q    <= 1'b0;
    end else begin
      len_lo_q      <= len_lo_d;
      acc_q         <= acc_d;
      resp_q        <= resp_d;
      cnt_q         <= cnt_d;
      bidx_q        <= bidx_d;
      word_q        <= word_d;
      gap_q         <= gap_d;
      full_q        <= full_d;
      len_ovf_q     <= len_ovf_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      done_q        <= done_d;
      error_q       <= error_d;
      cpu_hold_q    <= cpu_hold_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign cpu_hold    = cpu_hold_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: directed plus randomized frames,
// compared against a byte-level frame model (checksum sum, expected writes
// and response computed from the frame contents).
module tb_uart_boot_loader;
  import boot_loader_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int TO_CYC = 100;

  logic              clk = 1'b0;
  logic              rstb, upgrade_en_b, rx_valid, tx_busy;
  logic [7:0]        rx_data;
  logic              tx_valid, mem_wr_en, cpu_hold, done, error;
  logic [7:0]        tx_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wr_data;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]        tx_log[$];
  logic [ADDR_W-1:0] wa_log[$];
  logic [31:0]       wd_log[$];
  logic [31:0]       words[$];

  always #5 clk = ~clk;

  uart_boot_loader #(.XLEN(32), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rstb(rstb), .upgrade_en_b(upgrade_en_b), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_valid(tx_valid), .tx_data(tx_data), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  // Record RAM writes and responses away from the active edge.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      wa_log.push_back(mem_addr);
      wd_log.push_back(mem_wr_data);
    end
    if (tx_valid) tx_log.push_back(tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
    tick($urandom_range(0, 3));
  endtask

  task automatic clear_logs();
    tx_log.delete();
    wa_log.delete();
    wd_log.delete();
  endtask

  // Sends SYNC, length, the first ndata data bytes of words[], and optionally CSUM+delta.
  task automatic send_frame(input int n, input logic [7:0] delta, input int ndata, input bit with_csum);
    logic [15:0] nn;
    logic [7:0]  sum, b;
    nn  = n[15:0];
    sum = nn[7:0] + nn[15:8];
    send_byte(8'hA5);
    send_byte(nn[7:0]);
    send_byte(nn[15:8]);
    for (int i = 0; i < n * 4 && i < ndata; i++) begin
      b   = 8'(words[i / 4] >> (8 * (i % 4)));
      sum = sum + b;
      send_byte(b);
    end
    if (with_csum) send_byte(sum + delta);
  endtask

  // Full frame with model check: writes, response byte, done/error.
  task automatic run_frame(input string tag, input int n, input logic [7:0] delta);
    int          nwr;
    logic [7:0]  exp_resp;
    clear_logs();
    send_frame(n, delta, n * 4, 1'b1);
    for (int c = 0; c < 200 && tx_log.size() == 0; c++) tick(1);
    tick(3);
    nwr      = (n > DEPTH) ? DEPTH : n;
    exp_resp = (delta == 8'd0 && n <= DEPTH) ? 8'h06 : 8'h15;
    chk({tag, "_ntx"}, 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) chk({tag, "_resp"}, 32'(tx_log[0]), 32'(exp_resp));
    chk({tag, "_done"}, 32'(done), 32'(exp_resp == 8'h06));
    chk({tag, "_error"}, 32'(error), 32'(exp_resp == 8'h15));
    chk({tag, "_nwr"}, 32'(wa_log.size()), 32'(nwr));
    for (int i = 0; i < nwr && i < wa_log.size(); i++) begin
      chk({tag, "_waddr"}, 32'(wa_log[i]), 32'(i));
      chk({tag, "_wdata"}, wd_log[i], words[i]);
    end
  endtask

  initial begin
    int n, c;
    rstb = 1'b0; upgrade_en_b = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    tick(3);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wr_data, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    rstb = 1'b1;
    tick(2);
    chk("idle_hold", 32'(cpu_hold), 32'd0);
    upgrade_en_b = 1'b0;
    tick(4);
    chk("en_hold", 32'(cpu_hold), 32'd1);

    // Directed: two known words, good then bad checksum, then empty frame.
    words = {32'h00000013, 32'hDEADBEEF};
    run_frame("good2", 2, 8'd0);
    run_frame("badcs", 2, 8'd1);
    words.delete();
    run_frame("empty", 0, 8'd0);

    // Randomized frames.
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(0, 6);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      run_frame("rand", n, ($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0);
    end

    // Length beyond RAM depth: only DEPTH words written, NAK.
    words.delete();
    for (int i = 0; i < DEPTH + 2; i++) words.push_back($urandom);
    run_frame("ovf", DEPTH + 2, 8'd0);

    // Timeout after 5 data bytes.
    words = {$urandom, $urandom};
    clear_logs();
    send_frame(2, 8'd0, 5, 1'b0);
    tick(3 * TO_CYC);
    chk("to_nwr", 32'(wa_log.size()), 32'd1);
    if (wa_log.size() > 0) chk("to_wdata", wd_log[0], words[0]);
    chk("to_ntx", 32'(tx_log.size()), 32'd0);
    chk("to_error", 32'(error), 32'd1);
    chk("to_done", 32'(done), 32'd0);
    chk("to_idle", 32'(dut.state_q == ST_IDLE), 32'd1);

    // Abort by releasing the switch mid-DATA.
    words = {$urandom, $urandom, $urandom};
    clear_logs();
    send_frame(3, 8'd0, 6, 1'b0);
    upgrade_en_b = 1'b1;
    c = 0;
    while (cpu_hold && c < 20) begin
      tick(1);
      c++;
    end
    chk("ab_hold_lat", 32'(c <= 4), 32'd1);
    tick(5);
    chk("ab_hold", 32'(cpu_hold), 32'd0);
    chk("ab_error", 32'(error), 32'd1);
    chk("ab_nwr", 32'(wa_log.size()), 32'd1);
    chk("ab_ntx", 32'(tx_log.size()), 32'd0);
    chk("ab_idle", 32'(dut.state_q == ST_IDLE), 32'd1);
    upgrade_en_b = 1'b0;
    tick(5);
    run_frame("after_ab", 3, 8'd0);

    // Transmitter busy for 50 cycles while the response is pending.
    words = {$urandom};
    clear_logs();
    tx_busy = 1'b1;
    send_frame(1, 8'd0, 4, 1'b1);
    tick(50);
    chk("busy_notx", 32'(tx_log.size()), 32'd0);
    tx_busy = 1'b0;
    tick(1);
    @(negedge clk);
    chk("busy_pulse", 32'(tx_valid), 32'd1);
    tick(5);
    chk("busy_ntx", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) chk("busy_resp", 32'(tx_log[0]), 32'h06);
    chk("busy_done", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
